// File: rtl/cmov.sv
// cmov: constant-time conditional copy of one of two 64-bit word buffers into a destination region.
// Optional build macro CMOV_ZEROIZE_EN clears the datapath registers once the copy has finished.
module cmov (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  ilen,
  input  logic        verify_true,
  output logic [8:0]  rd_address,
  output logic        rd_base_sel,
  input  logic [63:0] din,
  output logic [8:0]  wr_address,
  output logic        wr_en,
  output logic [63:0] dout,
  output logic        done
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_A     = 3'd1,
    S_B     = 3'd2,
    S_C     = 3'd3,
    S_FLUSH = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [9:0]  r_i;
  logic [9:0]  r_len;
  logic        r_sel;
  logic [63:0] r_din0;
  logic [63:0] r_dout;
  logic [8:0]  r_wr_address;
  logic        r_wr_en;
  logic [9:0]  w_len;
  logic [9:0]  w_i_inc;
  logic [63:0] w_mask;
  logic [63:0] w_mix;

  // Length saturation, counter increment and the branch-free select of the two source words.
  always_comb begin
    w_len   = (ilen > 10'd512) ? 10'd512 : ilen;
    w_i_inc = r_i + 10'd1;
    w_mask  = {64{r_sel}};
    w_mix   = (r_din0 & w_mask) | (din & ~w_mask);
  end

  // Next-state logic; the path through A/B/C never depends on the select flag.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT: begin
        if (w_len == 10'd0) begin
          w_next = S_DONE;
        end else begin
          w_next = S_A;
        end
      end
      S_A:     w_next = S_B;
      S_B:     w_next = S_C;
      S_C: begin
        if (w_i_inc == r_len) begin
          w_next = S_FLUSH;
        end else begin
          w_next = S_A;
        end
      end
      S_FLUSH: w_next = S_DONE;
      S_DONE:  w_next = S_DONE;
      default: w_next = S_INIT;
    endcase
  end

  // State, counter and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_INIT;
      r_i          <= 10'd0;
      r_len        <= 10'd0;
      r_sel        <= 1'b0;
      r_din0       <= 64'd0;
      r_dout       <= 64'd0;
      r_wr_address <= 9'd0;
      r_wr_en      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wr_en <= (r_state == S_C);
      case (r_state)
        S_INIT: begin
          r_sel <= verify_true;
          r_i   <= 10'd0;
          r_len <= w_len;
        end
        S_B: begin
          r_din0 <= din;
        end
        S_C: begin
          r_dout       <= w_mix;
          r_wr_address <= r_i[8:0];
          r_i          <= w_i_inc;
        end
        S_FLUSH: begin
`ifdef CMOV_ZEROIZE_EN
          // Wipe key and fallback material once the last strobe has gone out.
          r_din0 <= 64'd0;
          r_dout <= 64'd0;
          r_sel  <= 1'b0;
`else
          r_din0 <= r_din0;
`endif
        end
        default: begin
          r_i <= r_i;
        end
      endcase
    end
  end

  assign rd_address  = r_i[8:0];
  assign rd_base_sel = (r_state == S_B);
  assign done        = (r_state == S_DONE);
  assign wr_address  = r_wr_address;
  assign wr_en       = r_wr_en;
  assign dout        = r_dout;

endmodule

// File: doc/cmov.md
# cmov

Constant-time conditional copy stage for Saber decapsulation, placed directly downstream of the ciphertext comparator. It consumes the comparator's `verify_true` flag and copies one of two equal-length 64-bit buffers in the shared data memory into a destination region: source 0 (re-derived key K') when the flag is 1, source 1 (secret fallback z) when it is 0. Address sequence, cycle count and write pattern do not depend on the flag.

## Interface
- No parameters.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset; the deasserting edge also starts one operation.
- `ilen` input 10: number of 64-bit words to copy; valid range 0..512, larger values saturate to 512.
- `verify_true` input 1: select flag from the comparator; sampled once per operation.
- `rd_address` output 9: word offset for the read port; the top level adds the base.
- `rd_base_sel` output 1: 0 selects source 0, 1 selects source 1.
- `din` input 64: read data, valid one cycle after the address is presented.
- `wr_address` output 9: word offset in the destination region.
- `wr_en` output 1: one-cycle write strobe.
- `dout` output 64: write data.
- `done` output 1: high and held once the operation has finished.

## Operation
- States: INIT, A, B, C, FLUSH, DONE.
- INIT:
  - `sel_r <= verify_true`; word counter i = 0.
  - If `ilen==0`, go to DONE. Otherwise go to A.
- A: present (base 0, i). `rd_base_sel=0`.
- B: `din0 <= din` (src0[i]); present (base 1, i).
- C: `din` = src1[i].
  - Register `dout <= (din0 & M) | (din & ~M)`, where `M = {64{sel_r}}`. No data-dependent branch or mux enable is allowed.
  - Register `wr_address <= i`, `wr_en <= 1`, then `i <= i+1`.
  - If `i+1 == ilen`, go to FLUSH. Otherwise go to A.
- FLUSH: the last write strobe is on the bus; go to DONE.
- DONE: holds until `rst`.
- Combinational outputs:
  - `rd_address = i[8:0]`.
  - `rd_base_sel = (state==B)`.
  - `done = (state==DONE)`.
- Registered output: `wr_en` is high only in the cycle after each C.
- Reset values: `rd_address=0`, `rd_base_sel=0`, `wr_address=0`, `wr_en=0`, `dout=0`, `done=0`. The state returns to INIT, `i=0` and `sel_r=0`.

## Timing
- Cycle 0 is the first cycle with `rst` low (INIT).
- Word k occupies cycles 3k+1 (A), 3k+2 (B) and 3k+3 (C). Its write strobe is in cycle 3k+4.
- For `ilen=N>0`:
  - FLUSH is cycle 3N+1 and carries the last `wr_en`.
  - `done` rises in cycle 3N+2.
- For `ilen=0`: `done` rises in cycle 1 and `wr_en` never asserts.
- Steady-state throughput is one word per 3 cycles, fixed.
- Changes to `verify_true` after INIT are ignored until the next reset.
- Reset mid-operation:
  - The next edge with `rst` high aborts the operation; `wr_en` is 0 from that edge on.
  - No partial write occurs after reset.
  - A restart begins from word 0.
- A read address and a write strobe share a cycle (A of word k+1 with write of word k). The destination region must not overlap either source.

## Configuration
- `CMOV_ZEROIZE_EN` defined:
  - On the edge leaving FLUSH, `din0`, `dout` and `sel_r` are cleared to 0, so no key or z material remains in block registers after `done`.
  - `done` timing is unchanged.
- `CMOV_ZEROIZE_EN` undefined: those registers keep their last values until reset.

## Test plan
- `ilen=4`, `verify_true=1`, src0 words `0x1111…1`..`0x4444…4`, src1 all `0xFFFF…F`.
  - Destination words 0..3 must equal the src0 words.
  - Exactly 4 `wr_en` pulses, in cycles 4, 7, 10 and 13.
  - `done` rises in cycle 14.
- Same buffers with `verify_true=0`.
  - Destination must equal src1.
  - Read address/base sequence and cycle-by-cycle `wr_en` trace must be identical to the previous run (constant time).
- `ilen=0`: `done` high in cycle 1; zero writes; `rd_address` stays 0.
- `ilen=600`: exactly 512 writes, with `wr_address` 0..511; `done` in cycle 1538.
- `rst` pulsed in cycle 8 of an `ilen=4` run:
  - No `wr_en` during or after the reset cycle until the restart.
  - After the restart, all 4 words are written correctly.
- Under `CMOV_ZEROIZE_EN`, run `ilen=2`, `verify_true=1`, src0 `0xDEADBEEF_CAFEBABE`.
  - Destination is correct.
  - After `done`, `dout` and internal `din0` read 0.
  - Without the macro, `dout` still holds the last word.
